sys_ctrl_regs: RTL and testbench
================================

Name: sys_ctrl_regs

Overview:
- Parametrised system-control register bank, addressed by IOC over the same cs/fetch/load bus as the other control modules.
- Generalises version/ID, debug-mode, TX-gap and TX-control-word registers in data width, gap width and channel counts.
- Adds sticky W1C error capture, a saturating clear-on-read error-event counter, a masked interrupt output, self-clearing command pulses and a registered read-valid strobe.
- Sits between the SPI/IOC decoder and the TX/FIFO/SMI datapath controls.

Parameters:
DATA_W, 8, bus and register data width (>=8)
IOC_W, 5, IOC address width
GAP_W, 4, tx_sample_gap width (<=DATA_W)
N_ERR, 4, number of error sources (<=DATA_W)
N_CMD, 4, number of command pulse outputs (<=DATA_W)
MODULE_VERSION, 2, read-only constant, DATA_W bits
SYSTEM_VERSION, 1, read-only constant, DATA_W bits
MANU_ID, 1, read-only constant, DATA_W bits

Ports:
i_sys_clk  in  1  system clock; all logic on rising edge
i_rst  in  1  asynchronous, active-high reset
i_ioc  in  IOC_W  register address
i_data_in  in  DATA_W  write data
i_cs  in  1  module select; fetch/load ignored when low
i_fetch_cmd  in  1  read strobe, one cycle
i_load_cmd  in  1  write strobe, one cycle
i_err  in  N_ERR  level error sources, synchronous to i_sys_clk
o_data_out  out  DATA_W  registered read data
o_data_valid  out  1  one-cycle pulse, cycle after an accepted fetch
o_debug_modes  out  4  [0] fifo_push, [1] fifo_pull, [2] smi_test, [3] loopback_tx
o_tx_sample_gap  out  GAP_W  TX inter-sample gap
o_tx_control_word  out  DATA_W  TX control word
o_cmd_pulse  out  N_CMD  self-clearing command strobes
o_irq  out  1  registered OR of masked sticky errors

Behaviour:
Reset (i_rst high, asynchronous):
- All outputs, registers, the counter and the i_err delay register go to 0.
- Reset mid-transaction discards the transaction; no pulse survives reset.

Access rules:
- Accepted fetch = i_cs & i_fetch_cmd. Accepted load = i_cs & i_load_cmd & ~i_fetch_cmd; fetch has priority and a simultaneous load is dropped.
- Read latency is 1 cycle. o_data_out updates on the edge after an accepted fetch and holds until the next accepted fetch. o_data_valid is high for exactly that cycle.
- Read data is zero-extended to DATA_W.
- Unmapped IOC: reads return 0, writes are ignored.

Register map (IOC, access, content):
- 0x00 RO MODULE_VERSION; 0x01 RO SYSTEM_VERSION; 0x02 RO MANU_ID
- 0x03 RW1C err_state[N_ERR-1:0]
- 0x04 RO-COR err_count
- 0x05 RW debug_modes[3:0]
- 0x06 RW tx_sample_gap[GAP_W-1:0]
- 0x07 RW tx_control_word
- 0x08 WO command; reads return 0
- 0x09 RW scratch
- 0x0A RW irq_mask[N_ERR-1:0]

Error logic:
- err_state[i] sets on any cycle with i_err[i]=1.
- Writing 1 to bit i of 0x03 clears err_state[i]; writing 0 has no effect.
- Set and clear in the same cycle: set wins, bit stays 1.
- err_d <= i_err every cycle. An event occurs in any cycle where (i_err & ~err_d) != 0; multiple rising bits in one cycle count as one event.
- err_count increments by 1 per event and saturates at 2^DATA_W-1 (no wrap).
- Fetch of 0x04 returns the pre-clear value and clears the counter. If an event coincides with that fetch, the counter becomes 1.
- o_irq <= |(err_state & irq_mask), one cycle behind err_state.

Commands:
- Load to 0x08 drives o_cmd_pulse <= i_data_in[N_CMD-1:0] for exactly one cycle, then 0.
- Back-to-back loads produce back-to-back pulses.

Test Plan:
- Reset released; fetch 0x00/0x01/0x02 -> o_data_out 0x02/0x01/0x01, o_data_valid one cycle each, one cycle after the strobe.
- Load 0x06 with 0xFF (GAP_W=4) then fetch 0x06 -> o_tx_sample_gap=0xF, read 0x0F; load 0x07=0xA5 -> o_tx_control_word=0xA5.
- Pulse i_err[2] high for 1 cycle; irq_mask=0x04 -> err_state=0x04, o_irq=1 one cycle later; W1C 0x04 in the same cycle as another i_err[2] pulse -> bit stays 1; a later W1C with no source -> 0, o_irq drops.
- Toggle i_err[0] 300 times (DATA_W=8) -> fetch 0x04 returns 0xFF (saturated), immediate re-fetch returns 0; an event coincident with the clearing fetch -> re-fetch returns 1.
- Load 0x08=0x05 -> o_cmd_pulse=0x5 for one cycle then 0x0; simultaneous fetch+load to 0x09 -> scratch unchanged, read returns old value.
- Assert i_rst mid-sequence with debug_modes=0xF -> all outputs 0 immediately, no o_data_valid or o_cmd_pulse after release.

Source files
------------

// File: rtl/sys_ctrl_regs_if.sv
// rtl/sys_ctrl_regs_if.sv - IOC register bus between the decoder (master) and sys_ctrl_regs (slave)
interface sys_ctrl_regs_if #(
    parameter int DATA_W = 8,
    parameter int IOC_W  = 5
);
    logic [IOC_W-1:0]  i_ioc;
    logic [DATA_W-1:0] i_data_in;
    logic              i_cs;
    logic              i_fetch_cmd;
    logic              i_load_cmd;
    logic [DATA_W-1:0] o_data_out;
    logic              o_data_valid;

    modport master (
        output i_ioc, i_data_in, i_cs, i_fetch_cmd, i_load_cmd,
        input  o_data_out, o_data_valid
    );

    modport slave (
        input  i_ioc, i_data_in, i_cs, i_fetch_cmd, i_load_cmd,
        output o_data_out, o_data_valid
    );
endinterface

// File: rtl/sys_ctrl_regs.sv
// rtl/sys_ctrl_regs.sv - system-control register bank: IDs, debug/TX controls, error capture, IRQ, command pulses
module sys_ctrl_regs #(
    parameter int                DATA_W         = 8,
    parameter int                IOC_W          = 5,
    parameter int                GAP_W          = 4,
    parameter int                N_ERR          = 4,
    parameter int                N_CMD          = 4,
    parameter logic [DATA_W-1:0] MODULE_VERSION = 2,
    parameter logic [DATA_W-1:0] SYSTEM_VERSION = 1,
    parameter logic [DATA_W-1:0] MANU_ID        = 1
) (
    input  logic              i_sys_clk,
    input  logic              i_rst,
    sys_ctrl_regs_if.slave    bus,
    input  logic [N_ERR-1:0]  i_err,
    output logic [3:0]        o_debug_modes,
    output logic [GAP_W-1:0]  o_tx_sample_gap,
    output logic [DATA_W-1:0] o_tx_control_word,
    output logic [N_CMD-1:0]  o_cmd_pulse,
    output logic              o_irq
);

    localparam logic [IOC_W-1:0] A_MODVER = IOC_W'(5'h00);
    localparam logic [IOC_W-1:0] A_SYSVER = IOC_W'(5'h01);
    localparam logic [IOC_W-1:0] A_MANUID = IOC_W'(5'h02);
    localparam logic [IOC_W-1:0] A_ERRST  = IOC_W'(5'h03);
    localparam logic [IOC_W-1:0] A_ERRCNT = IOC_W'(5'h04);
    localparam logic [IOC_W-1:0] A_DEBUG  = IOC_W'(5'h05);
    localparam logic [IOC_W-1:0] A_GAP    = IOC_W'(5'h06);
    localparam logic [IOC_W-1:0] A_TXCTL  = IOC_W'(5'h07);
    localparam logic [IOC_W-1:0] A_CMD    = IOC_W'(5'h08);
    localparam logic [IOC_W-1:0] A_SCRTCH = IOC_W'(5'h09);
    localparam logic [IOC_W-1:0] A_IRQMSK = IOC_W'(5'h0A);

    logic              fetch_ok;
    logic              load_ok;
    logic [N_ERR-1:0]  err_state;
    logic [N_ERR-1:0]  err_d;
    logic [N_ERR-1:0]  irq_mask;
    logic [N_ERR-1:0]  w1c_mask;
    logic [DATA_W-1:0] err_count;
    logic [DATA_W-1:0] scratch;
    logic [DATA_W-1:0] rd_data;
    logic              err_event;

    // Fetch wins over a simultaneous load; the load is dropped entirely.
    assign fetch_ok  = bus.i_cs & bus.i_fetch_cmd;
    assign load_ok   = bus.i_cs & bus.i_load_cmd & ~bus.i_fetch_cmd;
    assign w1c_mask  = (load_ok && bus.i_ioc == A_ERRST) ? bus.i_data_in[N_ERR-1:0] : '0;
    assign err_event = |(i_err & ~err_d);

    always_comb begin
        rd_data = '0;
        case (bus.i_ioc)
            A_MODVER: rd_data = MODULE_VERSION;
            A_SYSVER: rd_data = SYSTEM_VERSION;
            A_MANUID: rd_data = MANU_ID;
            A_ERRST:  rd_data[N_ERR-1:0] = err_state;
            A_ERRCNT: rd_data = err_count;
            A_DEBUG:  rd_data[3:0] = o_debug_modes;
            A_GAP:    rd_data[GAP_W-1:0] = o_tx_sample_gap;
            A_TXCTL:  rd_data = o_tx_control_word;
            A_SCRTCH: rd_data = scratch;
            A_IRQMSK: rd_data[N_ERR-1:0] = irq_mask;
            default:  rd_data = '0;
        endcase
    end

    always_ff @(posedge i_sys_clk or posedge i_rst) begin
        if (i_rst) begin
            bus.o_data_out    <= '0;
            bus.o_data_valid  <= 1'b0;
            o_debug_modes     <= '0;
            o_tx_sample_gap   <= '0;
            o_tx_control_word <= '0;
            o_cmd_pulse       <= '0;
            o_irq             <= 1'b0;
            err_state         <= '0;
            err_d             <= '0;
            irq_mask          <= '0;
            err_count         <= '0;
            scratch           <= '0;
        end else begin
            bus.o_data_valid <= fetch_ok;
            if (fetch_ok) begin
                bus.o_data_out <= rd_data;
            end

            if (load_ok) begin
                case (bus.i_ioc)
                    A_DEBUG:  o_debug_modes     <= bus.i_data_in[3:0];
                    A_GAP:    o_tx_sample_gap   <= bus.i_data_in[GAP_W-1:0];
                    A_TXCTL:  o_tx_control_word <= bus.i_data_in;
                    A_SCRTCH: scratch           <= bus.i_data_in;
                    A_IRQMSK: irq_mask          <= bus.i_data_in[N_ERR-1:0];
                    default:  ;
                endcase
            end

            o_cmd_pulse <= (load_ok && bus.i_ioc == A_CMD) ? bus.i_data_in[N_CMD-1:0] : '0;

            // A live source re-sets its bit after the W1C mask is applied, so set wins.
            err_state <= (err_state & ~w1c_mask) | i_err;
            err_d     <= i_err;
            o_irq     <= |(err_state & irq_mask);

            if (fetch_ok && bus.i_ioc == A_ERRCNT) begin
                err_count <= err_event ? DATA_W'(1) : '0;
            end else if (err_event && err_count != '1) begin
                err_count <= err_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sys_ctrl_regs.sv
// tb/tb_sys_ctrl_regs.sv - directed self-checking bench for sys_ctrl_regs
module tb_sys_ctrl_regs;

    logic       clk;
    logic       rst;
    logic [3:0] err;
    logic [3:0] debug_modes;
    logic [3:0] tx_gap;
    logic [7:0] tx_ctl;
    logic [3:0] cmd_pulse;
    logic       irq;

    int compared;
    int mismatched;

    sys_ctrl_regs_if #(.DATA_W(8), .IOC_W(5)) bus ();

    sys_ctrl_regs #(
        .DATA_W(8), .IOC_W(5), .GAP_W(4), .N_ERR(4), .N_CMD(4),
        .MODULE_VERSION(8'd2), .SYSTEM_VERSION(8'd1), .MANU_ID(8'd1)
    ) dut (
        .i_sys_clk        (clk),
        .i_rst            (rst),
        .bus              (bus),
        .i_err            (err),
        .o_debug_modes    (debug_modes),
        .o_tx_sample_gap  (tx_gap),
        .o_tx_control_word(tx_ctl),
        .o_cmd_pulse      (cmd_pulse),
        .o_irq            (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_fetch(input logic [4:0] a, output logic [7:0] d, output logic v);
        @(negedge clk);
        bus.i_cs = 1'b1; bus.i_fetch_cmd = 1'b1; bus.i_ioc = a;
        @(negedge clk);
        d = bus.o_data_out; v = bus.o_data_valid;
        bus.i_cs = 1'b0; bus.i_fetch_cmd = 1'b0;
    endtask

    task automatic do_load(input logic [4:0] a, input logic [7:0] d);
        @(negedge clk);
        bus.i_cs = 1'b1; bus.i_load_cmd = 1'b1; bus.i_ioc = a; bus.i_data_in = d;
        @(negedge clk);
        bus.i_cs = 1'b0; bus.i_load_cmd = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge clk);
        @(negedge clk);
        compared++;
        if ({bus.o_data_out, bus.o_data_valid, debug_modes, tx_gap, tx_ctl, cmd_pulse, irq} !== 30'd0) begin
            mismatched++;
            $display("FAIL reset_outputs: got dout=%h vld=%b dbg=%h gap=%h ctl=%h cmd=%h irq=%b, want all 0",
                     bus.o_data_out, bus.o_data_valid, debug_modes, tx_gap, tx_ctl, cmd_pulse, irq);
        end
        rst = 1'b0;
    endtask

    task automatic test_versions;
        logic [7:0] d;
        logic       v;
        logic [7:0] exp_d [3];
        exp_d[0] = 8'h02; exp_d[1] = 8'h01; exp_d[2] = 8'h01;
        for (int i = 0; i < 3; i++) begin
            do_fetch(5'(i), d, v);
            compared++;
            if (d !== exp_d[i] || v !== 1'b1) begin
                mismatched++;
                $display("FAIL version_read[%0d]: got data=%h valid=%b, want data=%h valid=1", i, d, v, exp_d[i]);
            end
        end
        @(negedge clk);
        compared++;
        if (bus.o_data_valid !== 1'b0 || bus.o_data_out !== 8'h01) begin
            mismatched++;
            $display("FAIL valid_one_cycle: got valid=%b data=%h, want valid=0 data=01", bus.o_data_valid, bus.o_data_out);
        end
    endtask

    task automatic test_rw;
        logic [7:0] d;
        logic       v;
        do_load(5'h06, 8'hFF);
        compared++;
        if (tx_gap !== 4'hF) begin
            mismatched++;
            $display("FAIL gap_out: got %h, want f", tx_gap);
        end
        do_fetch(5'h06, d, v);
        compared++;
        if (d !== 8'h0F) begin
            mismatched++;
            $display("FAIL gap_read: got %h, want 0f", d);
        end
        do_load(5'h07, 8'hA5);
        compared++;
        if (tx_ctl !== 8'hA5) begin
            mismatched++;
            $display("FAIL txctl_out: got %h, want a5", tx_ctl);
        end
        do_load(5'h1F, 8'h77);
        do_fetch(5'h1F, d, v);
        compared++;
        if (d !== 8'h00 || v !== 1'b1) begin
            mismatched++;
            $display("FAIL unmapped_read: got data=%h valid=%b, want 00 valid=1", d, v);
        end
        do_load(5'h08, 8'h00);
        do_fetch(5'h08, d, v);
        compared++;
        if (d !== 8'h00) begin
            mismatched++;
            $display("FAIL cmd_read: got %h, want 00", d);
        end
    endtask

    task automatic test_errors;
        logic [7:0] d;
        logic       v;
        do_load(5'h0A, 8'h04);
        @(negedge clk); err = 4'h4;
        @(negedge clk); err = 4'h0;
        compared++;
        if (irq !== 1'b0) begin
            mismatched++;
            $display("FAIL irq_lag: got %b, want 0", irq);
        end
        @(negedge clk);
        compared++;
        if (irq !== 1'b1) begin
            mismatched++;
            $display("FAIL irq_set: got %b, want 1", irq);
        end
        do_fetch(5'h03, d, v);
        compared++;
        if (d !== 8'h04) begin
            mismatched++;
            $display("FAIL err_state_set: got %h, want 04", d);
        end
        @(negedge clk);
        bus.i_cs = 1'b1; bus.i_load_cmd = 1'b1; bus.i_ioc = 5'h03; bus.i_data_in = 8'h04; err = 4'h4;
        @(negedge clk);
        bus.i_cs = 1'b0; bus.i_load_cmd = 1'b0; err = 4'h0;
        do_fetch(5'h03, d, v);
        compared++;
        if (d !== 8'h04 || irq !== 1'b1) begin
            mismatched++;
            $display("FAIL set_beats_clear: got state=%h irq=%b, want 04 irq=1", d, irq);
        end
        do_load(5'h03, 8'h04);
        do_fetch(5'h03, d, v);
        compared++;
        if (d !== 8'h00 || irq !== 1'b0) begin
            mismatched++;
            $display("FAIL w1c_clear: got state=%h irq=%b, want 00 irq=0", d, irq);
        end
        do_fetch(5'h04, d, v);
        compared++;
        if (d !== 8'h02) begin
            mismatched++;
            $display("FAIL err_count_two: got %h, want 02", d);
        end
    endtask

    task automatic test_counter;
        logic [7:0] d;
        logic       v;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk); err = 4'h1;
            @(negedge clk); err = 4'h0;
        end
        do_fetch(5'h04, d, v);
        compared++;
        if (d !== 8'hFF) begin
            mismatched++;
            $display("FAIL count_saturate: got %h, want ff", d);
        end
        do_fetch(5'h04, d, v);
        compared++;
        if (d !== 8'h00) begin
            mismatched++;
            $display("FAIL count_cor: got %h, want 00", d);
        end
        @(negedge clk);
        bus.i_cs = 1'b1; bus.i_fetch_cmd = 1'b1; bus.i_ioc = 5'h04; err = 4'h1;
        @(negedge clk);
        bus.i_cs = 1'b0; bus.i_fetch_cmd = 1'b0; err = 4'h0;
        d = bus.o_data_out;
        compared++;
        if (d !== 8'h00) begin
            mismatched++;
            $display("FAIL count_coincident_read: got %h, want 00", d);
        end
        do_fetch(5'h04, d, v);
        compared++;
        if (d !== 8'h01) begin
            mismatched++;
            $display("FAIL count_coincident_event: got %h, want 01", d);
        end
    endtask

    task automatic test_cmd;
        logic [7:0] d;
        logic       v;
        do_load(5'h08, 8'h05);
        compared++;
        if (cmd_pulse !== 4'h5) begin
            mismatched++;
            $display("FAIL cmd_pulse_on: got %h, want 5", cmd_pulse);
        end
        @(negedge clk);
        compared++;
        if (cmd_pulse !== 4'h0) begin
            mismatched++;
            $display("FAIL cmd_pulse_off: got %h, want 0", cmd_pulse);
        end
        @(negedge clk);
        bus.i_cs = 1'b1; bus.i_load_cmd = 1'b1; bus.i_ioc = 5'h08; bus.i_data_in = 8'h01;
        @(negedge clk);
        bus.i_data_in = 8'h02;
        compared++;
        if (cmd_pulse !== 4'h1) begin
            mismatched++;
            $display("FAIL cmd_b2b_first: got %h, want 1", cmd_pulse);
        end
        @(negedge clk);
        bus.i_cs = 1'b0; bus.i_load_cmd = 1'b0;
        compared++;
        if (cmd_pulse !== 4'h2) begin
            mismatched++;
            $display("FAIL cmd_b2b_second: got %h, want 2", cmd_pulse);
        end
        do_load(5'h09, 8'h3C);
        @(negedge clk);
        bus.i_cs = 1'b1; bus.i_fetch_cmd = 1'b1; bus.i_load_cmd = 1'b1; bus.i_ioc = 5'h09; bus.i_data_in = 8'hC3;
        @(negedge clk);
        bus.i_cs = 1'b0; bus.i_fetch_cmd = 1'b0; bus.i_load_cmd = 1'b0;
        compared++;
        if (bus.o_data_out !== 8'h3C || bus.o_data_valid !== 1'b1 || cmd_pulse !== 4'h0) begin
            mismatched++;
            $display("FAIL fetch_load_priority_read: got data=%h valid=%b, want 3c valid=1", bus.o_data_out, bus.o_data_valid);
        end
        do_fetch(5'h09, d, v);
        compared++;
        if (d !== 8'h3C) begin
            mismatched++;
            $display("FAIL scratch_unchanged: got %h, want 3c", d);
        end
    endtask

    task automatic test_reset_mid;
        logic [7:0] d;
        logic       v;
        do_load(5'h05, 8'h0F);
        compared++;
        if (debug_modes !== 4'hF) begin
            mismatched++;
            $display("FAIL debug_set: got %h, want f", debug_modes);
        end
        @(negedge clk);
        bus.i_cs = 1'b1; bus.i_load_cmd = 1'b1; bus.i_ioc = 5'h08; bus.i_data_in = 8'h0F;
        #2 rst = 1'b1;
        #1;
        compared++;
        if ({bus.o_data_out, bus.o_data_valid, debug_modes, tx_gap, tx_ctl, cmd_pulse, irq} !== 30'd0) begin
            mismatched++;
            $display("FAIL async_reset: got dout=%h vld=%b dbg=%h gap=%h ctl=%h cmd=%h irq=%b, want all 0",
                     bus.o_data_out, bus.o_data_valid, debug_modes, tx_gap, tx_ctl, cmd_pulse, irq);
        end
        @(negedge clk);
        bus.i_cs = 1'b0; bus.i_load_cmd = 1'b0;
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            compared++;
            if (cmd_pulse !== 4'h0 || bus.o_data_valid !== 1'b0) begin
                mismatched++;
                $display("FAIL post_reset_quiet[%0d]: got cmd=%h valid=%b, want 0 0", i, cmd_pulse, bus.o_data_valid);
            end
        end
        do_fetch(5'h05, d, v);
        compared++;
        if (d !== 8'h00) begin
            mismatched++;
            $display("FAIL debug_after_reset: got %h, want 00", d);
        end
    endtask

    initial begin
        compared = 0;
        mismatched = 0;
        rst = 1'b1;
        err = 4'h0;
        bus.i_cs = 1'b0; bus.i_fetch_cmd = 1'b0; bus.i_load_cmd = 1'b0;
        bus.i_ioc = 5'h00; bus.i_data_in = 8'h00;
        test_reset;
        test_versions;
        test_rw;
        test_errors;
        test_counter;
        test_cmd;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
